// File: rtl/maze_pkg.sv
// Shared definitions for the maze front-end: loader state encoding, default
// maze geometry and the row-address width also used by the solver datapath.
package maze_pkg;

   localparam int MAZE_ROWS = 16;
   localparam int MAZE_COLS = 16;
   localparam int ROW_AW    = $clog2(MAZE_ROWS);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_START_HI = 3'd2,
      ST_START_LO = 3'd3,
      ST_WAIT     = 3'd4,
      ST_REPORT   = 3'd5
   } loader_state_e;

   // Bits needed for a counter running 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/maze_loader_cnt.sv
// Up-counter with synchronous clear, count enable and a terminal-count flag;
// wraps to zero when enabled at the terminal value.
module maze_loader_cnt #(
   parameter int WIDTH = 4,
   parameter int TERM  = 15
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             tc_o
);

   localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERM);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign tc_o  = (cnt_q == TERM_VAL);
   assign cnt_o = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tc_o ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/maze_loader.sv
// Streams a maze into memory one row per handshake, pulses start for the
// solver controller, then latches solved / unsolved / timeout status.
module maze_loader
   import maze_pkg::*;
#(
   parameter int ROWS       = MAZE_ROWS,
   parameter int COLS       = MAZE_COLS,
   parameter int START_HOLD = 2,
   parameter int TIMEOUT    = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_req,
   input  logic                       abort,
   input  logic                       in_valid,
   input  logic [COLS-1:0]            in_data,
   output logic                       in_ready,
   output logic                       mem_wr_en,
   output logic [cnt_width(ROWS)-1:0] mem_addr,
   output logic [COLS-1:0]            mem_wdata,
   output logic                       start,
   input  logic                       done,
   input  logic                       fail,
   output logic                       busy,
   output logic                       solved,
   output logic                       unsolved,
   output logic                       timeout
);

   localparam int AW = cnt_width(ROWS);
   localparam int HW = cnt_width(START_HOLD);
   localparam int TW = cnt_width(TIMEOUT);

   loader_state_e state_q;
   logic          start_q;
   logic          solved_q;
   logic          unsolved_q;
   logic          timeout_q;

   logic          accept;
   logic          row_tc;
   logic          hold_tc;
   logic          wait_tc;
   logic [AW-1:0] row_cnt;
   logic [HW-1:0] hold_cnt_unused;
   logic [TW-1:0] wait_cnt_unused;

   assign in_ready  = (state_q == ST_LOAD);
   assign accept    = in_ready & in_valid;
   // The write path is combinational so a row lands in memory on the accept cycle.
   assign mem_wr_en = accept;
   assign mem_addr  = row_cnt;
   assign mem_wdata = in_data;

   assign start    = start_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_REPORT);
   assign solved   = solved_q;
   assign unsolved = unsolved_q;
   assign timeout  = timeout_q;

   maze_loader_cnt #(.WIDTH(AW), .TERM(ROWS - 1)) u_row_cnt (
      .clk    (clk),
      .rst_ni (rst),
      .clr_i  (abort || (state_q != ST_LOAD)),
      .en_i   (accept),
      .cnt_o  (row_cnt),
      .tc_o   (row_tc)
   );

   maze_loader_cnt #(.WIDTH(HW), .TERM(START_HOLD - 1)) u_hold_cnt (
      .clk    (clk),
      .rst_ni (rst),
      .clr_i  (abort || (state_q != ST_START_HI)),
      .en_i   (state_q == ST_START_HI),
      .cnt_o  (hold_cnt_unused),
      .tc_o   (hold_tc)
   );

   maze_loader_cnt #(.WIDTH(TW), .TERM(TIMEOUT - 1)) u_wait_cnt (
      .clk    (clk),
      .rst_ni (rst),
      .clr_i  (abort || (state_q != ST_WAIT)),
      .en_i   (state_q == ST_WAIT),
      .cnt_o  (wait_cnt_unused),
      .tc_o   (wait_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         solved_q   <= 1'b0;
         unsolved_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else if (abort) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         solved_q   <= 1'b0;
         unsolved_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_REPORT: begin
               if (load_req) begin
                  state_q    <= ST_LOAD;
                  solved_q   <= 1'b0;
                  unsolved_q <= 1'b0;
                  timeout_q  <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (accept && row_tc) begin
                  state_q <= ST_START_HI;
                  start_q <= 1'b1;
               end
            end
            ST_START_HI: begin
               if (hold_tc) begin
                  state_q <= ST_START_LO;
                  start_q <= 1'b0;
               end
            end
            ST_START_LO: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               // fail outranks done, and any answer outranks the timeout
               if (fail) begin
                  unsolved_q <= 1'b1;
                  state_q    <= ST_REPORT;
               end else if (done) begin
                  solved_q <= 1'b1;
                  state_q  <= ST_REPORT;
               end else if (wait_tc) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_REPORT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               start_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/maze_loader.md
Name: maze_loader

Overview:
- Front-end writer for the rat-in-maze solver.
- Accepts a maze one row per handshake over a valid/ready stream and writes each row into the maze memory that the solver controller later reads.
- Once the last row is written, generates the start press-and-release sequence the solver controller expects, then waits for the controller's done or fail and latches a result status.
- Sits between the host/testbench stream and the Rat_Controller plus maze memory pair.

Parameters:
ROWS, 16, number of maze rows (one write per row)
COLS, 16, bits per row (1 = wall, 0 = open)
START_HOLD, 2, cycles start is held high before release (>=1)
TIMEOUT, 4096, max cycles spent in WAIT before reporting timeout (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
load_req  input  1  one-cycle pulse; begins a load when idle
abort  input  1  return to IDLE from any state, clearing status
in_valid  input  1  row data valid
in_data  input  COLS  row bits, row order 0..ROWS-1
in_ready  output  1  loader accepts a row this cycle
mem_wr_en  output  1  maze memory write strobe
mem_addr  output  $clog2(ROWS)  row address
mem_wdata  output  COLS  row data to memory
start  output  1  to solver controller start input
done  input  1  solver controller done
fail  input  1  solver controller fail
busy  output  1  high in any state other than IDLE/REPORT
solved  output  1  sticky result: solver reported done
unsolved  output  1  sticky result: solver reported fail
timeout  output  1  sticky result: no answer within TIMEOUT

Behaviour:
- Reset (rst=0, async): state IDLE, row counter 0, hold and timeout counters 0, all outputs 0.
- States: IDLE, LOAD, START_HI, START_LO, WAIT, REPORT.
- IDLE:
  - in_ready=0.
  - load_req=1 -> LOAD; clears solved/unsolved/timeout and the row counter.
- LOAD:
  - in_ready=1.
  - Accept when in_valid&in_ready. Same cycle: mem_wr_en=1, mem_addr=row counter, mem_wdata=in_data (combinational, zero latency).
  - Counter increments on each accept.
  - Accept with counter==ROWS-1 -> START_HI; counter wraps to 0.
  - No accept -> stay, no write.
  - mem_wr_en is 0 in every other state.
- START_HI:
  - start=1 for exactly START_HOLD cycles (hold counter), then -> START_LO.
- START_LO:
  - start=0 for one cycle, then -> WAIT.
  - The controller starts on the falling edge of start and has already reset its datapath.
- WAIT:
  - Timeout counter increments each cycle.
  - done=1 -> solved=1, go to REPORT.
  - fail=1 -> unsolved=1, go to REPORT.
  - done and fail in the same cycle -> unsolved wins (solved stays 0).
  - Counter reaches TIMEOUT-1 with neither asserted -> timeout=1, go to REPORT.
  - done/fail take priority over timeout in the same cycle.
- REPORT:
  - Status flags hold; busy=0.
  - load_req -> LOAD, clearing flags (a new maze is loaded).
- Ignored inputs:
  - load_req in LOAD/START_HI/START_LO/WAIT.
  - done/fail outside WAIT.
- abort=1 (synchronous):
  - From any state -> IDLE next cycle; counters and flags clear, start drops.
  - abort wins over every other event.
  - A row presented with abort is still written this cycle if in_ready=1.
- Async reset mid-load leaves memory partially written; no rollback is required.

Decomposition:
- Shared package maze_pkg:
  - loader state enum (typedef, 3-bit encoding);
  - ROWS/COLS defaults;
  - row-address width constant, reused by the controller's X/Y datapath.
- One natural sub-module: maze_loader_cnt, a generic up-counter with clear, enable and terminal-count output.
  - Instantiated three times: row, start-hold, timeout.
- FSM and status flags stay in maze_loader.

Test Plan:
- Normal solve: load_req, stream 16 rows with in_valid held high -> 16 consecutive mem_wr_en pulses, addresses 0..15 in order; start high exactly 2 cycles then low; done pulse in WAIT -> solved=1, busy=0, in REPORT.
- Backpressure/gaps: toggle in_valid every other cycle -> writes occur only when in_valid=1; addresses stay sequential; exactly 16 writes; start follows the 16th.
- Fail with simultaneous done: in WAIT drive done=1 and fail=1 in the same cycle -> unsolved=1, solved=0.
- Timeout: TIMEOUT=8, never assert done/fail -> timeout=1 exactly 8 cycles after entering WAIT.
- Abort: abort during row 5 of LOAD -> next cycle IDLE, in_ready=0, no start pulse. A subsequent load_req restarts at mem_addr=0.
- Async reset: drop rst while in START_HI -> start=0 immediately (no clock edge); all flags 0; state IDLE after release.
